// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: synchronises sclk/cs_bar/mosi into clk, receives MSB-first bytes on mosi
// and returns a buffered response byte on miso.
module spi_slave_responder #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs_bar,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_abort
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DATA_WIDTH);

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_last_q, cs_last_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_last_q <= 1'b0;
      cs_last_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_bar};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_last_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_last_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_last_q;
  assign sclk_fall = ~sclk_s & sclk_last_q;
  assign cs_rise   = cs_s & ~cs_last_q;
  assign cs_fall   = ~cs_s & cs_last_q;

  state_e                state_q, state_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  // The newest bit comes straight from mosi_s, so only DATA_WIDTH-1 bits need storing.
  logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                  buf_full_q, buf_full_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_underrun_q, tx_underrun_d;
  logic                  frame_abort_q, frame_abort_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      tx_buf_q      <= '0;
      buf_full_q    <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      tx_buf_q      <= tx_buf_d;
      buf_full_q    <= buf_full_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    tx_buf_d      = tx_buf_q;
    buf_full_d    = buf_full_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    frame_abort_d = 1'b0;

    // A write while empty is kept even if LOAD fires in the same cycle.
    if (tx_valid && !buf_full_q) begin
      tx_buf_d   = tx_data;
      buf_full_d = 1'b1;
    end

    if (state_q != StIdle && cs_rise) begin
      if (bit_cnt_q != '0 && bit_cnt_q != CntFull) begin
        frame_abort_d = 1'b1;
        rx_shift_d    = '0;
      end
      tx_shift_d = '0;
      state_d    = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) state_d = StLoad;
        end
        StLoad: begin
          if (buf_full_q) begin
            tx_shift_d = tx_buf_q;
            buf_full_d = 1'b0;
          end else begin
            tx_shift_d    = '0;
            tx_underrun_d = 1'b1;
          end
          bit_cnt_d = '0;
          state_d   = StShift;
        end
        StShift: begin
          if (sclk_rise && bit_cnt_q != CntFull) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-3:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + CntW'(1);
            if (bit_cnt_q == CntFull - CntW'(1)) begin
              rx_data_d  = {rx_shift_q, mosi_s};
              rx_valid_d = 1'b1;
            end
          end else if (sclk_fall) begin
            if (bit_cnt_q == CntFull) begin
              state_d = StLoad;
            end else if (bit_cnt_q != '0) begin
              tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // tx_shift is cleared whenever the FSM is idle, so miso reads 0 there.
  assign miso        = tx_shift_q[DATA_WIDTH-1];
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: table of single-byte frames plus streaming,
// abort, mid-frame reset and held-tx_valid sequences.
`timescale 1ns / 1ps
module tb_spi_slave_responder;

  localparam time ClkHalf  = 10ns;
  localparam time SclkHalf = 500ns;

  logic       clk = 1'b0;
  logic       reset, sclk, cs_bar, mosi, miso;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, tx_underrun, frame_abort;

  int total = 0;
  int bad   = 0;

  int         rx_cnt = 0;
  int         un_cnt = 0;
  int         ab_cnt = 0;
  logic [7:0] rx_q[$];

  spi_slave_responder #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .cs_bar     (cs_bar),
    .mosi       (mosi),
    .miso       (miso),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_underrun(tx_underrun),
    .frame_abort(frame_abort)
  );

  always #(ClkHalf) clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt <= rx_cnt + 1;
      rx_q.push_back(rx_data);
    end
    if (tx_underrun) un_cnt <= un_cnt + 1;
    if (frame_abort) ab_cnt <= ab_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Mode 0: mosi set while sclk low, miso sampled on the rising edge. end_frame raises
  // cs_bar together with the final falling edge so no trailing LOAD occurs.
  task automatic spi_bits(input logic [7:0] out, input int nbits, input logic end_frame,
                          output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = out[7-i];
      #(SclkHalf);
      sclk = 1'b1;
      got  = {got[6:0], miso};
      #(SclkHalf);
      sclk = 1'b0;
      if (end_frame && i == nbits - 1) cs_bar = 1'b1;
    end
  endtask

  task automatic settle();
    repeat (20) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] mosi_byte;
    logic [7:0] tx_byte;
    logic       preload;
    logic [7:0] exp_miso;
    int         exp_underrun;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] got;
  int         rx0, un0, ab0;

  initial begin
    vecs[0] = '{mosi_byte: 8'h3C, tx_byte: 8'hA5, preload: 1'b1, exp_miso: 8'hA5, exp_underrun: 0};
    vecs[1] = '{mosi_byte: 8'h55, tx_byte: 8'h00, preload: 1'b0, exp_miso: 8'h00, exp_underrun: 1};
    vecs[2] = '{mosi_byte: 8'h81, tx_byte: 8'h5A, preload: 1'b1, exp_miso: 8'h5A, exp_underrun: 0};
    vecs[3] = '{mosi_byte: 8'hE7, tx_byte: 8'h0F, preload: 1'b1, exp_miso: 8'h0F, exp_underrun: 0};

    reset = 1'b0; sclk = 1'b0; cs_bar = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_miso", 32'(miso), 32'h0);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_tx_ready", 32'(tx_ready), 32'h1);
    check("reset_underrun", 32'(tx_underrun), 32'h0);
    check("reset_abort", 32'(frame_abort), 32'h0);
    reset = 1'b1;
    settle();

    // Single-byte frames from the table.
    for (int v = 0; v < 4; v++) begin
      rx0 = rx_cnt; un0 = un_cnt; ab0 = ab_cnt;
      if (vecs[v].preload) begin
        write_tx(vecs[v].tx_byte);
        check($sformatf("v%0d_ready_low", v), 32'(tx_ready), 32'h0);
      end
      cs_bar = 1'b0;
      #(SclkHalf);
      spi_bits(vecs[v].mosi_byte, 8, 1'b1, got);
      settle();
      check($sformatf("v%0d_rx_pulses", v), 32'(rx_cnt - rx0), 32'd1);
      check($sformatf("v%0d_rx_data", v), 32'(rx_data), 32'(vecs[v].mosi_byte));
      check($sformatf("v%0d_miso", v), 32'(got), 32'(vecs[v].exp_miso));
      check($sformatf("v%0d_underrun", v), 32'(un_cnt - un0), 32'(vecs[v].exp_underrun));
      check($sformatf("v%0d_abort", v), 32'(ab_cnt - ab0), 32'd0);
      check($sformatf("v%0d_ready_high", v), 32'(tx_ready), 32'h1);
      check($sformatf("v%0d_idle_miso", v), 32'(miso), 32'h0);
    end

    // Two bytes under one cs_bar low, second response written after the first LOAD.
    rx0 = rx_cnt; un0 = un_cnt;
    write_tx(8'h11);
    cs_bar = 1'b0;
    #(SclkHalf);
    check("stream_ready_after_load", 32'(tx_ready), 32'h1);
    write_tx(8'h22);
    spi_bits(8'h01, 8, 1'b0, got);
    check("stream_miso0", 32'(got), 32'h11);
    spi_bits(8'hFE, 8, 1'b1, got);
    check("stream_miso1", 32'(got), 32'h22);
    settle();
    check("stream_rx_pulses", 32'(rx_cnt - rx0), 32'd2);
    if (rx_cnt - rx0 == 2) begin
      check("stream_rx0", 32'(rx_q[rx0]), 32'h01);
      check("stream_rx1", 32'(rx_q[rx0+1]), 32'hFE);
    end
    check("stream_underrun", 32'(un_cnt - un0), 32'd0);

    // Completed 0x3C, then cs_bar raised after 5 bits of 0xFF.
    rx0 = rx_cnt; un0 = un_cnt; ab0 = ab_cnt;
    cs_bar = 1'b0;
    #(SclkHalf);
    spi_bits(8'h3C, 8, 1'b0, got);
    spi_bits(8'hFF, 5, 1'b0, got);
    #(SclkHalf);
    cs_bar = 1'b1;
    settle();
    check("abort_pulses", 32'(ab_cnt - ab0), 32'd1);
    check("abort_rx_pulses", 32'(rx_cnt - rx0), 32'd1);
    check("abort_rx_data", 32'(rx_data), 32'h3C);
    check("abort_underrun", 32'(un_cnt - un0), 32'd2);
    check("abort_miso", 32'(miso), 32'h0);

    // Reset asserted after 3 bits with a fresh byte sitting in the buffer.
    rx0 = rx_cnt; un0 = un_cnt; ab0 = ab_cnt;
    write_tx(8'h12);
    cs_bar = 1'b0;
    #(SclkHalf);
    spi_bits(8'hAA, 3, 1'b0, got);
    write_tx(8'h44);
    check("rst_ready_before", 32'(tx_ready), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(tx_ready), 32'h1);
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    cs_bar = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    settle();
    check("rst_abort", 32'(ab_cnt - ab0), 32'd0);
    check("rst_rx_pulses", 32'(rx_cnt - rx0), 32'd0);
    write_tx(8'h96);
    cs_bar = 1'b0;
    #(SclkHalf);
    spi_bits(8'h81, 8, 1'b1, got);
    settle();
    check("rst_after_rx", 32'(rx_data), 32'h81);
    check("rst_after_miso", 32'(got), 32'h96);
    check("rst_after_pulses", 32'(rx_cnt - rx0), 32'd1);

    // tx_valid held while the buffer is full: the second value must not land.
    write_tx(8'hC3);
    tx_data  = 8'h3E;
    tx_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("held_ready", 32'(tx_ready), 32'h0);
    tx_valid = 1'b0;
    cs_bar = 1'b0;
    #(SclkHalf);
    spi_bits(8'h5A, 8, 1'b1, got);
    settle();
    check("held_miso", 32'(got), 32'hC3);
    check("held_rx", 32'(rx_data), 32'h5A);
    check("held_ready_after", 32'(tx_ready), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
